// File: rtl/regfile_arb_pkg.sv
// Shared constants and types for the register-file write arbiter.
// Optional feature macro used by the top: REGFILE_WR_BYPASS_EN.
package regfile_arb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// Generic N-way round-robin arbiter; the search starts at the internal pointer
// and the pointer moves past the winner only when the caller signals a transfer.
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant,
  output logic         any_grant
);

  localparam int PTR_W = $clog2(N);

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;
  logic [PTR_W-1:0] win_idx;

  // Scan from the farthest offset down so the nearest requester wins last.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx       = '0;
    win_idx   = ptr_q;
    any_grant = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = PTR_W'((int'(ptr_q) + k) % N);
      if (req[idx]) begin
        win_idx   = idx;
        any_grant = 1'b1;
      end
    end
    grant = '0;
    if (any_grant) grant[win_idx] = 1'b1;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance) begin
      ptr_d = (win_idx == PTR_W'(N - 1)) ? '0 : win_idx + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port among NUM_REQ sources with a registered write stage.
// Define REGFILE_WR_BYPASS_EN to forward the in-flight write onto the read port.
module regfile_write_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = REG_DATA_W,
  parameter int ADDR_W  = REG_ADDR_W
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      hold,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      ctrl_writeEnable,
  output logic [ADDR_W-1:0]         ctrl_writeReg,
  output logic [DATA_W-1:0]         data_writeReg,
  input  logic [ADDR_W-1:0]         rd_addr,
  input  logic [DATA_W-1:0]         rd_data_in,
  output logic [DATA_W-1:0]         rd_data_out
);

  logic [NUM_REQ-1:0] grant;
  logic               any_grant;
  logic               xfer;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_data;

  logic               we_q, we_d;
  logic [ADDR_W-1:0]  wreg_q, wreg_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;

  // Grant is one-hot, so gating it once covers both the handshake and the pointer.
  assign req_ready = grant & {NUM_REQ{~hold & ~reset}};
  assign xfer      = any_grant & ~hold & ~reset;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .clock     (clock),
    .reset     (reset),
    .req       (req_valid),
    .advance   (xfer),
    .grant     (grant),
    .any_grant (any_grant)
  );

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        sel_addr = sel_addr | req_addr[i*ADDR_W +: ADDR_W];
        sel_data = sel_data | req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    we_d    = 1'b0;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    if (xfer) begin
      we_d    = (sel_addr != ADDR_W'(ZERO_REG));
      wreg_d  = sel_addr;
      wdata_d = sel_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      we_q    <= 1'b0;
      wreg_q  <= '0;
      wdata_q <= '0;
    end else begin
      we_q    <= we_d;
      wreg_q  <= wreg_d;
      wdata_q <= wdata_d;
    end
  end

  assign ctrl_writeEnable = we_q;
  assign ctrl_writeReg    = wreg_q;
  assign data_writeReg    = wdata_q;

`ifdef REGFILE_WR_BYPASS_EN
  // Covers the cycle where the file has not yet captured the strobed write.
  assign rd_data_out = (we_q && (wreg_q == rd_addr) && (rd_addr != ADDR_W'(ZERO_REG)))
                       ? wdata_q : rd_data_in;
`else
  logic unused_rd_addr;
  assign unused_rd_addr = ^rd_addr;
  assign rd_data_out    = rd_data_in;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench: a reference round-robin model pushes expected writes to a
// scoreboard queue at each grant; scenario tasks pop and compare after the edge.
module tb_regfile_write_arbiter;

  localparam int N  = 3;
  localparam int AW = 5;
  localparam int DW = 32;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic            clock = 1'b0;
  logic            reset;
  logic            hold;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            ctrl_writeEnable;
  logic [AW-1:0]   ctrl_writeReg;
  logic [DW-1:0]   data_writeReg;
  logic [AW-1:0]   rd_addr;
  logic [DW-1:0]   rd_data_in;
  logic [DW-1:0]   rd_data_out;

  int n_checks = 0;
  int n_fail   = 0;

  wr_t          sb[$];
  wr_t          e;
  int           m_ptr;
  logic [AW-1:0] m_last_addr;
  logic [DW-1:0] m_last_data;
  logic [N-1:0] exp_ready;
  logic [N-1:0] obs_ready;
  logic [DW-1:0] exp_rd;

  always #5 clock = ~clock;

  regfile_write_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clock            (clock),
    .reset            (reset),
    .hold             (hold),
    .req_valid        (req_valid),
    .req_addr         (req_addr),
    .req_data         (req_data),
    .req_ready        (req_ready),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg),
    .rd_addr          (rd_addr),
    .rd_data_in       (rd_data_in),
    .rd_data_out      (rd_data_out)
  );

  // One clock: model the grant at the falling edge, push the expected write,
  // then return just after the rising edge with the write stage updated.
  task automatic step();
    wr_t w;
    int  win;
    @(negedge clock);
    obs_ready = req_ready;
    exp_ready = '0;
    win = -1;
    if (!reset && !hold) begin
      for (int k = 0; k < N; k++) begin
        if (win < 0 && req_valid[(m_ptr + k) % N]) win = (m_ptr + k) % N;
      end
      if (win >= 0) exp_ready[win] = 1'b1;
    end
    if (reset) begin
      w = '0;
      m_ptr = 0;
      m_last_addr = '0;
      m_last_data = '0;
    end else if (win >= 0) begin
      m_last_addr = req_addr[win*AW +: AW];
      m_last_data = req_data[win*DW +: DW];
      w = '{we: (m_last_addr != '0), addr: m_last_addr, data: m_last_data};
      m_ptr = (win + 1) % N;
    end else begin
      w = '{we: 1'b0, addr: m_last_addr, data: m_last_data};
    end
    sb.push_back(w);
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic test_reset();
    reset = 1'b1; hold = 1'b0; req_valid = 3'b111;
    for (int c = 0; c < 2; c++) begin
      step();
      n_checks++;
      if (obs_ready !== 3'b000) begin n_fail++; $display("FAIL reset_ready got=%b exp=000", obs_ready); end
      e = (sb.size() > 0) ? sb.pop_front() : '1;
      n_checks++;
      if ({ctrl_writeEnable, ctrl_writeReg, data_writeReg} !== 38'd0)
        begin n_fail++; $display("FAIL reset_write got=%h exp=0", {ctrl_writeEnable, ctrl_writeReg, data_writeReg}); end
    end
  endtask

  task automatic test_release();
    logic [N-1:0] tbl [4];
    tbl[0] = 3'b001; tbl[1] = 3'b010; tbl[2] = 3'b100; tbl[3] = 3'b001;
    set_req(0, 5'd1, 32'h0000_0101);
    set_req(1, 5'd2, 32'h0000_0202);
    set_req(2, 5'd3, 32'h0000_0303);
    req_valid = 3'b111;
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      n_checks++;
      if (obs_ready !== exp_ready || obs_ready !== tbl[c])
        begin n_fail++; $display("FAIL release_ready[%0d] got=%b exp=%b", c, obs_ready, tbl[c]); end
      e = (sb.size() > 0) ? sb.pop_front() : '1;
      n_checks++;
      if ({ctrl_writeEnable, ctrl_writeReg, data_writeReg} !== e)
        begin n_fail++; $display("FAIL release_write[%0d] got=%h exp=%h", c, {ctrl_writeEnable, ctrl_writeReg, data_writeReg}, e); end
    end
  endtask

  task automatic test_single();
    req_valid = 3'b100;
    set_req(2, 5'd7, 32'hDEAD_BEEF);
    for (int c = 0; c < 2; c++) begin
      step();
      if (c == 0) req_valid = 3'b000;
      n_checks++;
      if (obs_ready !== exp_ready)
        begin n_fail++; $display("FAIL single_ready[%0d] got=%b exp=%b", c, obs_ready, exp_ready); end
      e = (sb.size() > 0) ? sb.pop_front() : '1;
      n_checks++;
      if ({ctrl_writeEnable, ctrl_writeReg, data_writeReg} !== e)
        begin n_fail++; $display("FAIL single_write[%0d] got=%h exp=%h", c, {ctrl_writeEnable, ctrl_writeReg, data_writeReg}, e); end
    end
    n_checks++;
    if (e.we !== 1'b0 || data_writeReg !== 32'hDEAD_BEEF || ctrl_writeReg !== 5'd7)
      begin n_fail++; $display("FAIL single_retire got_we=%b reg=%0d exp_we=0 reg=7", ctrl_writeEnable, ctrl_writeReg); end
  endtask

  task automatic test_reg0();
    req_valid = 3'b001;
    set_req(0, 5'd0, 32'h0000_1234);
    step();
    n_checks++;
    if (obs_ready !== 3'b001) begin n_fail++; $display("FAIL reg0_ready got=%b exp=001", obs_ready); end
    e = (sb.size() > 0) ? sb.pop_front() : '1;
    n_checks++;
    if ({ctrl_writeEnable, ctrl_writeReg, data_writeReg} !== e || ctrl_writeEnable !== 1'b0)
      begin n_fail++; $display("FAIL reg0_write got=%h exp=%h", {ctrl_writeEnable, ctrl_writeReg, data_writeReg}, e); end
    req_valid = 3'b111;
    set_req(0, 5'd1, 32'h0000_0101);
    step();
    n_checks++;
    if (obs_ready !== 3'b010) begin n_fail++; $display("FAIL reg0_ptr_adv got=%b exp=010", obs_ready); end
    e = (sb.size() > 0) ? sb.pop_front() : '1;
    n_checks++;
    if ({ctrl_writeEnable, ctrl_writeReg, data_writeReg} !== e)
      begin n_fail++; $display("FAIL reg0_next_write got=%h exp=%h", {ctrl_writeEnable, ctrl_writeReg, data_writeReg}, e); end
  endtask

  task automatic test_hold();
    req_valid = 3'b111;
    for (int c = 0; c < 6; c++) begin
      hold = (c >= 1 && c <= 3);
      step();
      n_checks++;
      if (obs_ready !== exp_ready || (hold && obs_ready !== 3'b000))
        begin n_fail++; $display("FAIL hold_ready[%0d] got=%b exp=%b", c, obs_ready, exp_ready); end
      e = (sb.size() > 0) ? sb.pop_front() : '1;
      n_checks++;
      if ({ctrl_writeEnable, ctrl_writeReg, data_writeReg} !== e)
        begin n_fail++; $display("FAIL hold_write[%0d] got=%h exp=%h", c, {ctrl_writeEnable, ctrl_writeReg, data_writeReg}, e); end
    end
    hold = 1'b0;
  endtask

  task automatic test_reset_mid();
    req_valid = 3'b010;
    set_req(1, 5'd9, 32'h0909_0909);
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_checks++;
    if (obs_ready !== 3'b000) begin n_fail++; $display("FAIL rstmid_ready got=%b exp=000", obs_ready); end
    e = (sb.size() > 0) ? sb.pop_front() : '1;
    n_checks++;
    if ({ctrl_writeEnable, ctrl_writeReg, data_writeReg} !== e || ctrl_writeEnable !== 1'b0)
      begin n_fail++; $display("FAIL rstmid_write got=%h exp=%h", {ctrl_writeEnable, ctrl_writeReg, data_writeReg}, e); end
    req_valid = 3'b111;
    step();
    n_checks++;
    if (obs_ready !== 3'b001) begin n_fail++; $display("FAIL rstmid_ptr got=%b exp=001", obs_ready); end
    e = (sb.size() > 0) ? sb.pop_front() : '1;
    n_checks++;
    if ({ctrl_writeEnable, ctrl_writeReg, data_writeReg} !== e)
      begin n_fail++; $display("FAIL rstmid_next_write got=%h exp=%h", {ctrl_writeEnable, ctrl_writeReg, data_writeReg}, e); end
  endtask

  task automatic test_back_to_back();
    int cnt [N];
    for (int i = 0; i < N; i++) cnt[i] = 0;
    req_valid = 3'b111;
    for (int c = 0; c < 3 * N; c++) begin
      for (int i = 0; i < N; i++) set_req(i, AW'($urandom_range(0, 31)), $urandom);
      step();
      for (int i = 0; i < N; i++) if (obs_ready[i]) cnt[i]++;
      n_checks++;
      if (obs_ready !== exp_ready)
        begin n_fail++; $display("FAIL b2b_ready[%0d] got=%b exp=%b", c, obs_ready, exp_ready); end
      e = (sb.size() > 0) ? sb.pop_front() : '1;
      n_checks++;
      if ({ctrl_writeEnable, ctrl_writeReg, data_writeReg} !== e)
        begin n_fail++; $display("FAIL b2b_write[%0d] got=%h exp=%h", c, {ctrl_writeEnable, ctrl_writeReg, data_writeReg}, e); end
    end
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if (cnt[i] != 3) begin n_fail++; $display("FAIL fairness[%0d] got=%0d exp=3", i, cnt[i]); end
    end
  endtask

  task automatic test_bypass();
    req_valid = 3'b010;
    set_req(1, 5'd5, 32'hA5A5_A5A5);
    rd_addr = 5'd5;
    rd_data_in = 32'h0;
    step();
    req_valid = 3'b000;
`ifdef REGFILE_WR_BYPASS_EN
    exp_rd = 32'hA5A5_A5A5;
`else
    exp_rd = 32'h0;
`endif
    e = (sb.size() > 0) ? sb.pop_front() : '1;
    n_checks++;
    if ({ctrl_writeEnable, ctrl_writeReg, data_writeReg} !== e)
      begin n_fail++; $display("FAIL bypass_write got=%h exp=%h", {ctrl_writeEnable, ctrl_writeReg, data_writeReg}, e); end
    n_checks++;
    if (rd_data_out !== exp_rd) begin n_fail++; $display("FAIL bypass_hit got=%h exp=%h", rd_data_out, exp_rd); end
    rd_data_in = 32'h1111_2222;
    step();
    e = (sb.size() > 0) ? sb.pop_front() : '1;
    n_checks++;
    if (rd_data_out !== 32'h1111_2222) begin n_fail++; $display("FAIL bypass_idle got=%h exp=11112222", rd_data_out); end
  endtask

  initial begin
    reset = 1'b1; hold = 1'b0; req_valid = '0; req_addr = '0; req_data = '0;
    rd_addr = '0; rd_data_in = '0;
    m_ptr = 0; m_last_addr = '0; m_last_data = '0;
    test_reset();
    test_release();
    test_single();
    test_reg0();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    test_bypass();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
